decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Pipelined RV32I decode stage between fetch and register-read/execute.
//  - Splits each instruction into register/function fields and builds the
//    sign-extended immediate.
//  - Classifies the instruction format and flags illegal opcodes.
//  - Registers the result behind a valid/ready handshake with a 2-entry skid
//    buffer, so a downstream stall never drops or duplicates an instruction.
// PARAMETERS
//  XLEN        32            datapath width of pc and imm (32 or 64; fields fixed)
//  RESET_ADDR  32'h00000000  value driven on out_pc while reset/empty
//  SKID_DEPTH  2             buffer entries (1 = half-throughput, 2 = full rate)
// PORTS
//  clk           in   1     clock, all state on rising edge
//  rst           in   1     synchronous, active-high reset
//  flush         in   1     discard all buffered instructions (branch redirect)
//  in_valid      in   1     fetch presents instruction
//  in_ready      out  1     stage can accept this cycle
//  in_instr      in   32    raw instruction word
//  in_pc         in   XLEN  pc of in_instr
//  out_valid     out  1     decoded bundle valid
//  out_ready     in   1     downstream accepts bundle
//  out_pc        out  XLEN  pc of bundle
//  out_opcode    out  7     instr[6:0]
//  out_rd        out  5     dest reg; 0 for S/B/illegal
//  out_rs1       out  5     src1; 0 for U/J/illegal
//  out_rs2       out  5     src2; 0 for U/J/I/illegal
//  out_funct3    out  3     0 for U/J/illegal
//  out_funct7    out  7     instr[31:25] for R only, else 0
//  out_imm       out  XLEN  sign-extended immediate per format; 0 for R/illegal
//  out_fmt       out  3     R=0 I=1 S=2 B=3 U=4 J=5 ILL=7
//  out_illegal   out  1     opcode not in RV32I base set or instr[1:0]!=2'b11
// BEHAVIOUR
//  - Opcode map:
//    - R: 0110011.
//    - I: 0010011, 0000011, 1100111, 1110011, 0001111.
//    - S: 0100011.  B: 1100011.  U: 0110111, 0010111.  J: 1101111.
//    - Anything else is ILL.
//  - Immediate (bit 31 sign-extends to XLEN):
//    - I = instr[31:20].
//    - S = {instr[31:25], instr[11:7]}.
//    - B = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
//    - U = {instr[31:12], 12'b0}.
//    - J = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
//  - Latency: an accepted input appears on out_* the next cycle when the
//    buffer is empty.
//  - Handshake:
//    - Transfer when valid && ready on either side.
//    - in_ready = (occupancy < SKID_DEPTH); depends only on registered state.
//    - out_* hold stable while out_valid && !out_ready.
//  - Ordering: strict FIFO. Simultaneous push and pop at full occupancy is
//    not allowed, because in_ready is already 0.
//  - Flush: clears occupancy the same edge; an in_valid presented during the
//    flush cycle is dropped.
//  - Flush and rst: out_valid=0 the next cycle. in_ready=1 the next cycle.
//  - Reset values: out_valid=0, in_ready=1, out_pc=RESET_ADDR, every other
//    out_* = 0.
//  - Reset mid-transfer discards all entries.
//  - Empty: out_* fields are driven 0 and out_pc=RESET_ADDR (no stale data).
// STRUCTURE
//  - Shared include rv32i_defs.vh: opcode localparams (OP_R, OP_IMM, OP_LOAD,
//    OP_JALR, OP_SYS, OP_FENCE, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC,
//    OP_JAL) and the FMT_* codes.
//  - Sub-module rv32i_field_decode: purely combinational instr -> fields/imm/fmt.
//  - decode_stage instantiates rv32i_field_decode and adds the skid buffer
//    plus occupancy counter.
// TESTING
//  - addi x1,x2,-1 (0xFFF10093) -> rd=1 rs1=2 rs2=0 f3=0 imm=0xFFFFFFFF fmt=1.
//  - sw x5,8(x2) (0x00512423) -> rd=0 rs1=2 rs2=5 f3=2 imm=8 fmt=2.
//  - lui x3,0x12345 (0x123451B7) -> rd=3 rs1=0 imm=0x12345000 fmt=4.
//  - Backpressure: out_ready=0, push A, B, C every cycle
//    -> in_ready=0 after 2 accepts.
//    -> out_ready=1 then emits A, B, then C, with no loss or duplication.
//  - Flush with 2 entries buffered and in_valid=1 -> next cycle out_valid=0,
//    in_ready=1; the dropped input is never emitted.
//  - 0x00000000 and opcode 0x0B -> out_illegal=1, fmt=7, all fields/imm=0,
//    pc passed through.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Purpose : shared RV32I decode definitions -- opcode map, format codes,
//           the decoded-field bundle and the opcode -> format classifier.
// Contents: OP_* opcode constants, fmt_e, fields_t, classify().
package decode_stage_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYS    = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  // Everything decoded from the instruction word except the XLEN-wide immediate.
  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;
    fmt_e       fmt;
    logic       illegal;
  } fields_t;

  // Every legal opcode ends in 2'b11, so a bad instr[1:0] lands in the default.
  function automatic fmt_e classify(input logic [6:0] op);
    fmt_e f;
    case (op)
      OP_R:                                        f = FMT_R;
      OP_IMM, OP_LOAD, OP_JALR, OP_SYS, OP_FENCE:  f = FMT_I;
      OP_STORE:                                    f = FMT_S;
      OP_BRANCH:                                   f = FMT_B;
      OP_LUI, OP_AUIPC:                            f = FMT_U;
      OP_JAL:                                      f = FMT_J;
      default:                                     f = FMT_ILL;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Purpose : fetch-side and execute-side handshake bundle of decode_stage.
// Ports   : in_valid/in_ready/in_instr/in_pc (fetch -> decode),
//           out_valid/out_ready/out_* (decode -> execute).
// Modports: master = environment (fetch + execute), slave = decode_stage.
interface decode_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [6:0]      out_opcode;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm, out_fmt, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm, out_fmt, out_illegal
  );
endinterface

// File: rtl/rv32i_field_decode.sv
// Purpose : purely combinational RV32I field extraction.
// Ports   : instr_i  - raw instruction word
//           fields_o - opcode/rd/rs1/rs2/funct3/funct7/fmt/illegal, with fields
//                      a format does not use forced to zero
//           imm_o    - immediate sign-extended from bit 31 to XLEN
module rv32i_field_decode
  import decode_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output fields_t         fields_o,
  output logic [XLEN-1:0] imm_o
);

  logic [31:0] imm32_s;
  fmt_e        fmt_s;

  assign fmt_s = classify(instr_i[6:0]);

  // Route each field only for the formats that actually carry it.
  always_comb begin
    fields_o         = '0;
    imm32_s          = 32'h0;
    fields_o.opcode  = instr_i[6:0];
    fields_o.fmt     = fmt_s;
    fields_o.illegal = (fmt_s == FMT_ILL);
    case (fmt_s)
      FMT_R: begin
        fields_o.rd     = instr_i[11:7];
        fields_o.rs1    = instr_i[19:15];
        fields_o.rs2    = instr_i[24:20];
        fields_o.funct3 = instr_i[14:12];
        fields_o.funct7 = instr_i[31:25];
      end
      FMT_I: begin
        fields_o.rd     = instr_i[11:7];
        fields_o.rs1    = instr_i[19:15];
        fields_o.funct3 = instr_i[14:12];
        imm32_s         = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      FMT_S: begin
        fields_o.rs1    = instr_i[19:15];
        fields_o.rs2    = instr_i[24:20];
        fields_o.funct3 = instr_i[14:12];
        imm32_s         = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      end
      FMT_B: begin
        fields_o.rs1    = instr_i[19:15];
        fields_o.rs2    = instr_i[24:20];
        fields_o.funct3 = instr_i[14:12];
        imm32_s         = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25],
                           instr_i[11:8], 1'b0};
      end
      FMT_U: begin
        fields_o.rd     = instr_i[11:7];
        imm32_s         = {instr_i[31:12], 12'h000};
      end
      FMT_J: begin
        fields_o.rd     = instr_i[11:7];
        imm32_s         = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20],
                           instr_i[30:21], 1'b0};
      end
      default: begin
        imm32_s = 32'h0;
      end
    endcase
  end

  // A signed size cast widens to XLEN by replicating bit 31.
  assign imm_o = XLEN'($signed(imm32_s));

endmodule

// File: rtl/decode_stage.sv
// Purpose : RV32I decode pipeline stage. Decodes on the way in and parks the
//           bundle in a SKID_DEPTH-entry FIFO so a downstream stall never
//           drops or duplicates an instruction.
// Ports   : clk   - rising-edge clock
//           rst   - synchronous active-high reset, empties the buffer
//           flush - empties the buffer; an input offered the same cycle is dropped
//           bus   - decode_stage_if.slave handshake (fetch in, bundle out)
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_ADDR = {XLEN{1'b0}},
  parameter int              SKID_DEPTH = 2
) (
  input logic           clk,
  input logic           rst,
  input logic           flush,
  decode_stage_if.slave bus
);

  localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CNT_W = $clog2(SKID_DEPTH + 1);

  fields_t         dec_fields_s;
  logic [XLEN-1:0] dec_imm_s;

  fields_t         fields_q [SKID_DEPTH];
  logic [XLEN-1:0] imm_q    [SKID_DEPTH];
  logic [XLEN-1:0] pc_q     [SKID_DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic    push_s, pop_s, valid_s;
  fields_t head_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SKID_DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  rv32i_field_decode #(.XLEN(XLEN)) u_field_decode (
    .instr_i  (bus.in_instr),
    .fields_o (dec_fields_s),
    .imm_o    (dec_imm_s)
  );

  // Handshake derives only from registered occupancy.
  assign valid_s      = (cnt_q != {CNT_W{1'b0}});
  assign bus.in_ready = (cnt_q < CNT_W'(SKID_DEPTH));
  assign push_s       = bus.in_valid && bus.in_ready && !flush;
  assign pop_s        = valid_s && bus.out_ready;

  // Next pointer/occupancy state; flush wins over any push or pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      rd_ptr_d = {PTR_W{1'b0}};
      wr_ptr_d = {PTR_W{1'b0}};
      cnt_d    = {CNT_W{1'b0}};
    end else begin
      if (push_s) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_s)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push_s, pop_s})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= {PTR_W{1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage; contents are masked on the outputs while empty, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fields_q[wr_ptr_q] <= dec_fields_s;
      imm_q[wr_ptr_q]    <= dec_imm_s;
      pc_q[wr_ptr_q]     <= bus.in_pc;
    end else begin
      fields_q[wr_ptr_q] <= fields_q[wr_ptr_q];
      imm_q[wr_ptr_q]    <= imm_q[wr_ptr_q];
      pc_q[wr_ptr_q]     <= pc_q[wr_ptr_q];
    end
  end

  // Head entry drives the outputs; an empty buffer shows zeros, never stale data.
  assign head_s          = valid_s ? fields_q[rd_ptr_q] : '0;
  assign bus.out_valid   = valid_s;
  assign bus.out_pc      = valid_s ? pc_q[rd_ptr_q]  : RESET_ADDR;
  assign bus.out_imm     = valid_s ? imm_q[rd_ptr_q] : {XLEN{1'b0}};
  assign bus.out_opcode  = head_s.opcode;
  assign bus.out_rd      = head_s.rd;
  assign bus.out_rs1     = head_s.rs1;
  assign bus.out_rs2     = head_s.rs2;
  assign bus.out_funct3  = head_s.funct3;
  assign bus.out_funct7  = head_s.funct7;
  assign bus.out_fmt     = head_s.fmt;
  assign bus.out_illegal = head_s.illegal;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(32)) bus ();

  decode_stage #(.XLEN(32), .RESET_ADDR(32'h0), .SKID_DEPTH(2)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } item_t;

  vec_t  vecs [10];
  item_t model_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_vec(input string tag, input vec_t v, input logic [31:0] pc);
    chk({tag, " valid"},  64'(bus.out_valid),   64'd1);
    chk({tag, " pc"},     64'(bus.out_pc),      64'(pc));
    chk({tag, " opcode"}, 64'(bus.out_opcode),  64'(v.opcode));
    chk({tag, " rd"},     64'(bus.out_rd),      64'(v.rd));
    chk({tag, " rs1"},    64'(bus.out_rs1),     64'(v.rs1));
    chk({tag, " rs2"},    64'(bus.out_rs2),     64'(v.rs2));
    chk({tag, " f3"},     64'(bus.out_funct3),  64'(v.f3));
    chk({tag, " f7"},     64'(bus.out_funct7),  64'(v.f7));
    chk({tag, " imm"},    64'(bus.out_imm),     64'(v.imm));
    chk({tag, " fmt"},    64'(bus.out_fmt),     64'(v.fmt));
    chk({tag, " ill"},    64'(bus.out_illegal), 64'(v.ill));
  endtask

  task automatic chk_empty(input string tag);
    vec_t z;
    z = '{32'h0, 7'h0, 5'h0, 5'h0, 5'h0, 3'h0, 7'h0, 32'h0, 3'h0, 1'b0};
    chk({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
    chk({tag, " valid"},    64'(bus.out_valid), 64'd0);
    chk({tag, " pc"},       64'(bus.out_pc), 64'd0);
    chk({tag, " fields"},
        64'({bus.out_opcode, bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_funct3,
             bus.out_funct7, bus.out_fmt, bus.out_illegal}),
        64'({z.opcode, z.rd, z.rs1, z.rs2, z.f3, z.f7, z.fmt, z.ill}));
    chk({tag, " imm"},      64'(bus.out_imm), 64'(z.imm));
  endtask

  // Reference decode computed arithmetically from the RV32I encoding rules.
  function automatic vec_t ref_decode(input logic [31:0] ins);
    vec_t v;
    int unsigned u;
    int s;
    int fmt;
    u = ins;
    s = $signed(ins);
    v.instr = ins; v.opcode = 7'(u % 128);
    v.rd = 5'h0; v.rs1 = 5'h0; v.rs2 = 5'h0; v.f3 = 3'h0; v.f7 = 7'h0; v.imm = 32'h0;
    case (u % 128)
      51:                fmt = 0;
      19, 3, 103, 115, 15: fmt = 1;
      35:                fmt = 2;
      99:                fmt = 3;
      55, 23:            fmt = 4;
      111:               fmt = 5;
      default:           fmt = 7;
    endcase
    v.fmt = 3'(fmt);
    v.ill = (fmt == 7);
    if (fmt inside {0, 1, 4, 5}) v.rd  = 5'((u / 128) % 32);
    if (fmt inside {0, 1, 2, 3}) v.rs1 = 5'((u / 32768) % 32);
    if (fmt inside {0, 2, 3})    v.rs2 = 5'((u / 1048576) % 32);
    if (fmt inside {0, 1, 2, 3}) v.f3  = 3'((u / 4096) % 8);
    if (fmt == 0)                v.f7  = 7'(u / 33554432);
    case (fmt)
      1: v.imm = 32'(s >>> 20);
      2: v.imm = 32'((s >>> 25) * 32 + int'((u / 128) % 32));
      3: v.imm = 32'(int'(((u / 128) % 2) * 2048 + ((u / 33554432) % 64) * 32
                        + ((u / 256) % 16) * 2) - ((u >= 32'h80000000) ? 4096 : 0));
      4: v.imm = 32'(u - (u % 4096));
      5: v.imm = 32'(int'(((u / 4096) % 256) * 4096 + ((u / 1048576) % 2) * 2048
                        + ((u / 2097152) % 1024) * 2) - ((u >= 32'h80000000) ? 1048576 : 0));
      default: v.imm = 32'h0;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [12];
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h0B};
    return {$urandom() >> 7, ops[$urandom_range(11, 0)]} & 32'hFFFFFFFF;
  endfunction

  initial begin
    vecs[0] = '{32'hFFF10093, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFF, 3'd1, 1'b0};
    vecs[1] = '{32'h00512423, 7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'h00, 32'h00000008, 3'd2, 1'b0};
    vecs[2] = '{32'h123451B7, 7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 3'd4, 1'b0};
    vecs[3] = '{32'h002081B3, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h00000000, 3'd0, 1'b0};
    vecs[4] = '{32'h402081B3, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h00000000, 3'd0, 1'b0};
    vecs[5] = '{32'h008000EF, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000008, 3'd5, 1'b0};
    vecs[6] = '{32'hFE000EE3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFC, 3'd3, 1'b0};
    vecs[7] = '{32'h00000000, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 3'd7, 1'b1};
    vecs[8] = '{32'hFFFFF00B, 7'h0B, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 3'd7, 1'b1};
    vecs[9] = '{32'h00000012, 7'h12, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 3'd7, 1'b1};

    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_instr = 32'h0; bus.in_pc = 32'h0; bus.out_ready = 1'b1;
    step(); step();
    chk_empty("reset");
    rst = 1'b0;

    // Table: streamed back to back, each bundle one cycle after acceptance.
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1; bus.in_instr = vecs[i].instr; bus.in_pc = 32'h1000 + 32'(i * 4);
      step();
      chk_vec($sformatf("vec%0d", i), vecs[i], 32'h1000 + 32'(i * 4));
    end
    bus.in_valid = 1'b0;
    step();
    chk_empty("drain");

    // Backpressure: A, B accepted, C held off until space frees up.
    bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    bus.in_instr = vecs[0].instr; bus.in_pc = 32'hA0;
    step(); chk("bp ready1", 64'(bus.in_ready), 64'd1);
    bus.in_instr = vecs[1].instr; bus.in_pc = 32'hB0;
    step(); chk("bp ready2", 64'(bus.in_ready), 64'd0);
    bus.in_instr = vecs[2].instr; bus.in_pc = 32'hC0;
    step(); chk("bp ready3", 64'(bus.in_ready), 64'd0);
    chk_vec("bp holdA", vecs[0], 32'hA0);
    bus.out_ready = 1'b1;
    step(); chk_vec("bp B", vecs[1], 32'hB0);
    step(); chk_vec("bp C", vecs[2], 32'hC0);
    bus.in_valid = 1'b0;
    step(); chk_empty("bp end");

    // Flush with two entries buffered and an input offered in the flush cycle.
    bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    bus.in_instr = vecs[3].instr; bus.in_pc = 32'h200; step();
    bus.in_pc = 32'h204; step();
    bus.in_pc = 32'h208; flush = 1'b1; step();
    flush = 1'b0; bus.in_valid = 1'b0;
    chk_empty("flush");
    bus.out_ready = 1'b1;
    step(); chk("flush no emit", 64'(bus.out_valid), 64'd0);

    // Reset in the middle of a transfer.
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_pc = 32'h300; step();
    rst = 1'b1; step();
    rst = 1'b0; bus.in_valid = 1'b0;
    chk_empty("mid reset");
    bus.out_ready = 1'b1;

    // Random traffic against the queue model.
    for (int c = 0; c < 3000; c++) begin
      bit   push, pop;
      vec_t e;
      bus.in_valid  = ($urandom_range(3, 0) != 0);
      bus.out_ready = ($urandom_range(2, 0) != 0);
      flush         = ($urandom_range(60, 0) == 0);
      bus.in_instr  = rand_instr();
      bus.in_pc     = $urandom() & 32'hFFFFFFFC;
      push = bus.in_valid && (model_q.size() < 2) && !flush;
      pop  = (model_q.size() > 0) && bus.out_ready;
      if (flush) model_q.delete();
      else begin
        if (pop) void'(model_q.pop_front());
        if (push) model_q.push_back('{bus.in_instr, bus.in_pc});
      end
      step();
      chk("rnd in_ready", 64'(bus.in_ready), 64'(model_q.size() < 2));
      if (model_q.size() > 0) begin
        e = ref_decode(model_q[0].instr);
        chk_vec("rnd", e, model_q[0].pc);
      end else begin
        chk("rnd empty", 64'(bus.out_valid), 64'd0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
